data_ram_resp: RTL
==================

Name: data_ram_resp

Overview:
- Data-memory responder at the far end of the MEM-stage data RAM interface (ce/we/sel/addr/data), with a big-endian byte-lane word RAM.
- Models a RAM with configurable access latency. Holds the pipeline with stallreq_o until each access completes.
- Returns the full read word; the MEM stage performs byte/halfword extraction. Writes commit only the lanes enabled by sel.

Parameters:
- ADDR_WIDTH, 10, word-index width; DEPTH = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, extra busy cycles per access (0..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- mem_ce_i  input  1  access request, level; held by the MEM stage while stalled
- mem_we_i  input  1  1 = write, 0 = read
- mem_addr_i  input  32  byte address; word index = addr[ADDR_WIDTH+1:2]
- mem_sel_i  input  4  byte lanes: sel[3]=data[31:24] (offset 0) .. sel[0]=data[7:0] (offset 3)
- mem_data_i  input  32  write data, lane-aligned
- mem_data_o  output  32  read word, registered
- stallreq_o  output  1  pipeline stall request, combinational from state and mem_ce_i
- err_o  output  1  one-cycle pulse: out-of-range access completed

Behaviour:
- Reset: state IDLE, wait counter 0, mem_data_o=0, err_o=0, stallreq_o=0. RAM contents are not reset.
- Reset mid-operation discards the pending access; an uncommitted write is never performed.
- FSM states are IDLE, BUSY and DONE.
- stallreq_o = (IDLE & mem_ce_i) | BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.
- IDLE:
  - On mem_ce_i=1, latch we/addr/sel/data.
  - If WAIT_CYCLES=0, go to DONE and execute the access at this edge.
  - Otherwise, load counter=WAIT_CYCLES-1 and go to BUSY.
- BUSY:
  - If mem_ce_i=0 (flush), abort: go to IDLE with no write and no data update.
  - Otherwise, if counter=0, execute the access and go to DONE; else decrement the counter.
  - Latched request fields are used, not live inputs.
- Execute:
  - In range means addr[31:ADDR_WIDTH+2]==0.
  - Write: for each lane i with sel[i]=1, byte i of the addressed word takes mem_data_i lane i. Other lanes are unchanged. sel=0000 writes nothing and is not an error.
  - Read: mem_data_o takes the full 32-bit word at the next edge, regardless of sel.
  - Out-of-range write: no RAM change.
  - Out-of-range read: mem_data_o=0.
- DONE:
  - err_o=1 for this cycle only, if the executed access was out of range.
  - Next state is IDLE unconditionally. mem_ce_i still high for the same request is ignored.
- Latency: a request first seen in IDLE at cycle T causes stall cycles T..T+WAIT_CYCLES; DONE falls at T+WAIT_CYCLES+1.
- A back-to-back request is recognised in the IDLE cycle after DONE.
- mem_data_o holds its value through writes, aborts and idle; only a completed read updates it.
- mem_addr_i[1:0] is ignored by the RAM; lane selection comes solely from sel.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - SW addr 0x10, data 0xDEADBEEF, sel 1111 -> stallreq high for 3 cycles, DONE on the 4th.
  - LW addr 0x10 -> mem_data_o=0xDEADBEEF in DONE, err_o=0.
- Byte lanes:
  - After word 0x11223344 at 0x20, write 0xAAAAAAAA sel 0100 (SB at 0x21) -> read returns 0x11AA3344.
  - Write sel 0011 data 0x0000BBCC -> read returns 0x11AABBCC.
- Out of range, ADDR_WIDTH=10:
  - Write at 0x00001000 -> err_o pulses 1 cycle in DONE; word 0 unchanged.
  - Read at 0x00001000 -> mem_data_o=0, err_o pulse.
- Abort:
  - Drop mem_ce_i during BUSY of a write 0x55555555 to 0x30 -> state returns to IDLE, stallreq=0 next cycle.
  - A later read of 0x30 returns the prior value.
- Reset mid-operation:
  - Assert rst in BUSY -> next cycle IDLE, stallreq_o=0, mem_data_o=0, no write committed.
- Zero wait and back-to-back, WAIT_CYCLES=0:
  - Read 0x40 then read 0x44 on consecutive requests -> pattern stall 1, DONE, stall 1, DONE.
  - Each DONE shows the correct word.

Source files
------------

// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage RAM port: a big-endian byte-lane word RAM
// with a configurable access latency. The pipeline is held by stallreq_o until each access completes.
module data_ram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [1:0]  o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LP_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_exec;
  logic                  w_ex_we;
  logic [31:0]           w_ex_addr;
  logic [3:0]            w_ex_sel;
  logic [31:0]           w_ex_wdata;
  logic                  w_ex_in_range;
  logic [ADDR_WIDTH-1:0] w_ex_idx;

  // Handshake: mem_ce_i is a level request held while stallreq_o=1; the access is
  // complete in the first cycle stallreq_o drops (DONE), where mem_data_o/err_o are valid.

  // With zero wait cycles the access executes straight from IDLE on the live inputs.
  always_comb begin
    w_exec = 1'b0;
    if (r_state == ST_IDLE) begin
      w_exec = mem_ce_i && (WAIT_CYCLES == 0);
    end else if (r_state == ST_BUSY) begin
      w_exec = mem_ce_i && (r_cnt == 4'd0);
    end
  end

  assign w_ex_we       = (r_state == ST_IDLE) ? mem_we_i   : r_we;
  assign w_ex_addr     = (r_state == ST_IDLE) ? mem_addr_i : r_addr;
  assign w_ex_sel      = (r_state == ST_IDLE) ? mem_sel_i  : r_sel;
  assign w_ex_wdata    = (r_state == ST_IDLE) ? mem_data_i : r_wdata;
  assign w_ex_in_range = (w_ex_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign w_ex_idx      = w_ex_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_ce_i) begin
          w_next_state = (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!mem_ce_i) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o  = ((r_state == ST_IDLE) && mem_ce_i) || (r_state == ST_BUSY);
    err_o       = (r_state == ST_DONE) && r_err;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_sel      <= 4'd0;
      r_wdata    <= 32'd0;
      r_err      <= 1'b0;
      mem_data_o <= 32'd0;
    end else begin
      if ((r_state == ST_IDLE) && mem_ce_i) begin
        r_we    <= mem_we_i;
        r_addr  <= mem_addr_i;
        r_sel   <= mem_sel_i;
        r_wdata <= mem_data_i;
        r_cnt   <= LP_CNT_LOAD;
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec) begin
        r_err <= !w_ex_in_range;
        if (!w_ex_we) begin
          mem_data_o <= w_ex_in_range ? r_mem[w_ex_idx] : 32'd0;
        end
      end
    end
  end

  // RAM contents are not reset; a reset edge still blocks a commit.
  always_ff @(posedge clk) begin
    if (w_exec && !rst && w_ex_we && w_ex_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_ex_sel[b]) begin
          r_mem[w_ex_idx][8*b +: 8] <= w_ex_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
